fifo_packetizer: RTL

- Drain stage that sits directly downstream of sync_fifo.
- Pulls WIDTH-bit words from the FIFO read port and emits fixed-length frames on a valid/ready stream: one header word, PKT_LEN payload words, then one XOR checksum word.
- Owns the FIFO read handshake and never issues a read while the FIFO is empty, so sync_fifo underflow cannot occur through this block.

---
 rtl/fifo_packetizer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_packetizer.sv
// Drains a sync_fifo read port into fixed-length valid/ready frames:
// header word, PKT_LEN payload words, then an XOR checksum word.
module fifo_packetizer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PKT_LEN = 4,
    parameter int unsigned HDR     = 32'hA5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_count
);

    localparam int unsigned      IDX_W    = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
    localparam logic [WIDTH-1:0] HDR_WORD = WIDTH'(HDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_FETCH,
        S_WAIT,
        S_DATA,
        S_CSUM
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   csum_q, csum_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   mdata_q, mdata_d;
    logic               xfer;

    assign xfer = valid_q & m_ready;

    // Next-state logic; the output registers are loaded from the next state so
    // they always describe the state being entered.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        fifo_rd_en = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_HDR;
                    csum_d  = '0;
                    idx_d   = '0;
                end
            end
            S_HDR: begin
                if (xfer) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                data_d  = fifo_rdata;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (xfer) begin
                    csum_d  = csum_q ^ data_q;
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = (idx_q == LAST_IDX) ? S_CSUM : S_FETCH;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = S_IDLE;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        valid_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
        last_d  = (state_d == S_CSUM);
        busy_d  = (state_d != S_IDLE);
        unique case (state_d)
            S_HDR:   mdata_d = HDR_WORD;
            S_DATA:  mdata_d = data_d;
            S_CSUM:  mdata_d = csum_d;
            default: mdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            csum_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            mdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            mdata_q <= mdata_d;
        end
    end

    assign m_valid   = valid_q;
    assign m_last    = last_q;
    assign m_data    = mdata_q;
    assign busy      = busy_q;
    assign pkt_count = cnt_q;

endmodule
